equiv_sweep: RTL
================

# equiv_sweep

Sequential exhaustive-equivalence checker for the gate-level exercises. It sweeps every input vector of width N_IN into two candidate implementations, one structural and one behavioural, and samples their outputs. It counts mismatches and reports pass/fail plus the first failing vector. It sits between the stimulus side (x_out) and the outputs of the two implementations under comparison (a_in, b_in), replacing hand-written `$monitor` truth-table inspection.

## Interface
- N_IN, 2: width of the swept input vector; 2^N_IN vectors per sweep.
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  begin sweep; sampled only in IDLE or DONE.
- a_in  input  1  output of implementation A, combinational from x_out.
- b_in  input  1  output of implementation B, combinational from x_out.
- x_out  output  N_IN  vector driven to both implementations.
- busy  output  1  high in DRIVE or SAMPLE.
- done  output  1  high in DONE.
- pass  output  1  valid when done; 1 iff err_count==0.
- err_count  output  N_IN+1  number of mismatching vectors in last sweep.
- first_bad  output  N_IN  lowest vector that mismatched; valid when first_bad_valid.
- first_bad_valid  output  1  at least one mismatch recorded this sweep.

## Operation
- FSM states: IDLE, DRIVE, SAMPLE, DONE.
- IDLE: x_out=0. start=1 -> DRIVE; clear err_count, first_bad, first_bad_valid; x_out=0.
- DRIVE: settle cycle; x_out held. Always -> SAMPLE.
- SAMPLE: compare a_in vs b_in at the closing edge.
  - On mismatch: err_count+1.
  - On the first mismatch of the sweep: first_bad<=x_out, first_bad_valid<=1.
  - If x_out == all-ones -> DONE; else x_out+1 -> DRIVE.
- DONE: x_out holds last vector; outputs frozen. start=1 -> same as IDLE start, clears results and resweeps; else stay.
- start in DRIVE/SAMPLE: ignored, no restart, no effect on counters.
- err_count never wraps: max value 2^N_IN fits in N_IN+1 bits.
- pass = done & ~first_bad_valid (combinational from registers).
- X/Z on a_in or b_in counts as a mismatch (use !== compare semantics in bench-visible model; RTL uses ^ with X treated as mismatch in simulation only).

## Timing
- Reset values: state=IDLE, x_out=0, busy=0, done=0, pass=0, err_count=0, first_bad=0, first_bad_valid=0.
- reset dominates start and every state; reset mid-sweep aborts to IDLE at that edge and clears all results.
- start sampled high at edge k (IDLE/DONE) -> busy=1, x_out=0 after edge k.
- 2 cycles per vector. Vector v is driven after edge k+2v and compared at edge k+2v+2.
- done=1 after edge k+2·2^N_IN; for N_IN=2, after edge k+8. busy falls at the same edge.
- Results update only at SAMPLE edges; no combinational path from a_in/b_in to any output.

## Structure
- Shared package guia_pkg: state encoding constants (IDLE=2'd0, DRIVE=2'd1, SAMPLE=2'd2, DONE=2'd3) and default N_IN.
- One sub-module: vec_counter (N_IN-bit counter with clear, enable, and terminal-count flag), instantiated for x_out. The FSM and result registers stay in equiv_sweep.

## Test plan
- Both inputs NOR(x1,x0) (structural-NAND NOR vs behavioural ~(x1|x0)), start pulse -> done after 8 cycles, pass=1, err_count=0, first_bad_valid=0.
- a=NOR, b=NAND -> mismatches at 01 and 10: err_count=2, first_bad=2'b01, pass=0.
- a=NOR, b=~NOR -> err_count=4, first_bad=2'b00, pass=0.
- reset asserted at the SAMPLE edge of vector 2 -> next cycle all outputs at reset values; new start gives a full 8-cycle sweep with correct results.
- start re-pulsed while busy -> ignored, done still at edge k+8. start in DONE with a=b -> err_count cleared to 0 after the new sweep, first_bad_valid=0.
- N_IN=3, a=b except vector 3'b101 -> done after 16 cycles, err_count=1, first_bad=3'b101.

Source files
------------

// File: rtl/guia_pkg.sv
// guia_pkg: shared sweep FSM state encoding and default swept-vector width
package guia_pkg;
  localparam int N_IN_DEF = 2;
  typedef enum logic [1:0] {IDLE = 2'd0, DRIVE = 2'd1, SAMPLE = 2'd2, DONE = 2'd3} state_t;
endpackage

// File: rtl/equiv_sweep_vec_counter.sv
// vec_counter: N-bit vector counter (clk, rst, clr_i, en_i -> q_o, tc_o at all-ones)
module vec_counter #(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [N-1:0] q_o,
  output logic         tc_o
);
  logic [N-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr_i ? '0 : en_i ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
  assign q_o  = cnt_q;
  assign tc_o = &cnt_q;
endmodule

// File: rtl/equiv_sweep.sv
// equiv_sweep: exhaustive A/B equivalence sweep (start, a_in, b_in -> x_out, busy, done, pass, err_count, first_bad, first_bad_valid)
module equiv_sweep
  import guia_pkg::*;
#(
  parameter int N_IN = N_IN_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            a_in,
  input  logic            b_in,
  output logic [N_IN-1:0] x_out,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic [N_IN-1:0] first_bad,
  output logic            first_bad_valid
);
  state_t          state_q;
  logic [N_IN:0]   err_q;
  logic [N_IN-1:0] fb_q;
  logic            fbv_q, go, samp, mis, tc;
  assign go   = start & (state_q == IDLE | state_q == DONE);
  assign samp = state_q == SAMPLE;
  assign mis  = (a_in ^ b_in) !== 1'b0;
  vec_counter #(.N(N_IN)) u_cnt (
    .clk  (clk),
    .rst  (reset),
    .clr_i(go),
    .en_i (samp & ~tc),
    .q_o  (x_out),
    .tc_o (tc)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      err_q   <= '0;
      fb_q    <= '0;
      fbv_q   <= 1'b0;
    end else if (go) begin
      state_q <= DRIVE;
      err_q   <= '0;
      fb_q    <= '0;
      fbv_q   <= 1'b0;
    end else begin
      state_q <= state_q == DRIVE ? SAMPLE : samp ? (tc ? DONE : DRIVE) : state_q;
      if (samp) begin
        err_q <= err_q + {{N_IN{1'b0}}, mis};
        if (mis & ~fbv_q) begin
          fb_q  <= x_out;
          fbv_q <= 1'b1;
        end
      end
    end
  end
  assign busy            = state_q == DRIVE | state_q == SAMPLE;
  assign done            = state_q == DONE;
  assign pass            = done & ~fbv_q;
  assign err_count       = err_q;
  assign first_bad       = fb_q;
  assign first_bad_valid = fbv_q;
endmodule
